srl16_fifo_ctrl: RTL
====================

Name: srl16_fifo_ctrl

Overview:
- Sequencer that turns a bank of WIDTH external 16-deep addressable shift-register primitives (one per data bit, shared CE/address) into a 17-entry valid/ready FIFO.
- Owns occupancy tracking, shift-enable generation, read-address generation and a registered output stage; the shift-register contents themselves are never reset.
- Used wherever the design needs small LUT-based elastic buffers.

Parameters:
- WIDTH, 8, data width; number of shift-register primitives driven in parallel.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- CLR  in  1  synchronous flush; empties FIFO.
- S_VALID  in  1  upstream word valid.
- S_READY  out  1  FIFO can accept a word this cycle.
- S_DATA  in  WIDTH  upstream word.
- M_VALID  out  1  output register holds a word.
- M_READY  in  1  downstream accepts the word.
- M_DATA  out  WIDTH  output register contents.
- SRL_CE  out  1  shift enable to all primitives.
- SRL_A  out  4  read address to all primitives.
- SRL_D  out  WIDTH  shift-in data; equals S_DATA combinationally.
- SRL_Q  in  WIDTH  addressed primitive outputs; combinational function of SRL_A.
- LEVEL  out  5  total words held (shift register + output register), 0..17.

Behaviour:
- State: cnt[4:0] (0..16 words in the shift register), M_VALID, M_DATA, S_READY (registered).
- Reset (RST=1, async): cnt=0, M_VALID=0, M_DATA=0, S_READY=0, LEVEL=0. S_READY rises on the first rising edge after RST falls.
- push = S_VALID & S_READY; pop = M_VALID & M_READY; out_free = ~M_VALID | M_READY.
- bypass = push & (cnt==0) & out_free: S_DATA loads M_DATA directly, SRL_CE=0. Latency from S_VALID&S_READY to M_VALID is 1 cycle.
- SRL_CE = push & ~bypass. The word shifts into position 0 and older words move up one.
- SRL_A = cnt-1 when cnt>0, else 0. Position cnt-1 always holds the oldest word.
- load = (cnt>0) & out_free: M_DATA <= SRL_Q, M_VALID <= 1.
- push & load in the same cycle: SRL_Q reflects pre-shift contents at cnt-1, so ordering is preserved; cnt is unchanged.
- When neither load nor bypass occurs: M_VALID <= M_VALID & ~M_READY. M_DATA holds its value while M_VALID=1 & M_READY=0.
- next_cnt = cnt + SRL_CE - load. It never exceeds 16 and never underflows.
- S_READY <= (next_cnt != 16), registered. Full (cnt=16) deasserts S_READY on the edge that reaches 16. It reasserts the cycle after the first load from full.
- LEVEL = cnt + M_VALID, combinational from state.
- CLR=1: cnt<=0, M_VALID<=0, push ignored (SRL_CE forced 0), S_READY<=1. M_DATA is not cleared. RST has priority over CLR.
- RST mid-operation discards all words. Stale shift-register contents are never presented, because load requires cnt>0.
- Back-pressure: M_DATA/M_VALID stable while M_VALID=1 & M_READY=0.
- X-safety: SRL_Q is only sampled when load=1.

Test Plan:
- Reset, then push 0xA5 on an idle FIFO -> next cycle M_VALID=1, M_DATA=0xA5, SRL_CE never asserted, LEVEL=1.
- Hold M_READY=0 and push 0x00..0x10 (17 words) -> words 1..16 shift in, S_READY=0 after the 17th accepted, LEVEL=17, M_DATA=0x00 stable.
- From full, M_READY=1 for 17 cycles -> M_DATA sequence 0x00..0x10 in order, SRL_A counts 15 down to 0, S_READY high again one cycle after the first pop, LEVEL ends at 0, M_VALID=0.
- With cnt=5, push and pop every cycle for 20 cycles -> cnt stays 5, output order equals input order, no gap in M_VALID.
- With LEVEL=9, assert CLR with S_VALID=1 -> next cycle LEVEL=0, M_VALID=0, S_READY=1, pushed word dropped; a subsequent push of 0x3C bypasses to M_DATA.
- Assert RST asynchronously (mid-cycle) with LEVEL=6 -> M_VALID, S_READY, LEVEL go to 0 immediately; S_READY=1 one edge after release; no old data emerges.

Source files
------------

// File: rtl/srl16_fifo_ctrl.sv
// Controller that turns WIDTH external 16-deep addressable shift registers into a
// 17-entry valid/ready FIFO with a registered output stage.
module srl16_fifo_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLR,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [WIDTH-1:0] S_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [WIDTH-1:0] M_DATA,
    output logic             SRL_CE,
    output logic [3:0]       SRL_A,
    output logic [WIDTH-1:0] SRL_D,
    input  logic [WIDTH-1:0] SRL_Q,
    output logic [4:0]       LEVEL
);

    localparam int unsigned CNT_W = 5;
    localparam int unsigned DEPTH = 16;

    logic [CNT_W-1:0] r_cnt;
    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_ready;

    logic             w_push;
    logic             w_out_free;
    logic             w_bypass;
    logic             w_load;
    logic             w_ce;
    logic [CNT_W-1:0] w_next_cnt;
    logic [3:0]       w_addr;

    // Handshake decode, shift enable and oldest-word address.
    always_comb begin
        w_push     = S_VALID & r_s_ready;
        w_out_free = ~r_m_valid | M_READY;
        w_bypass   = w_push & (r_cnt == '0) & w_out_free;
        w_load     = (r_cnt != '0) & w_out_free;
        w_ce       = w_push & ~w_bypass & ~CLR;
        w_addr     = 4'd0;
        if (r_cnt != '0) begin
            w_addr = 4'(r_cnt - CNT_W'(1));
        end
        w_next_cnt = r_cnt + CNT_W'(w_ce) - CNT_W'(w_load);
    end

    // Occupancy, output register and registered ready.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_ready <= 1'b0;
        end else if (CLR) begin
            r_cnt     <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b1;
        end else begin
            r_cnt     <= w_next_cnt;
            r_s_ready <= (w_next_cnt != CNT_W'(DEPTH));
            if (w_load) begin
                r_m_data  <= SRL_Q;
                r_m_valid <= 1'b1;
            end else if (w_bypass) begin
                r_m_data  <= S_DATA;
                r_m_valid <= 1'b1;
            end else begin
                r_m_valid <= r_m_valid & ~M_READY;
            end
        end
    end

    assign S_READY = r_s_ready;
    assign M_VALID = r_m_valid;
    assign M_DATA  = r_m_data;
    assign SRL_CE  = w_ce;
    assign SRL_A   = w_addr;
    assign SRL_D   = S_DATA;
    assign LEVEL   = r_cnt + CNT_W'(r_m_valid);

endmodule
